// File: rtl/frame_stream_scheduler.sv
// Raster reader for the RGB444 frame buffer, presented as an Avalon-ST video source.
// A 2-entry buffer absorbs the RAM read latency so the source keeps full rate under backpressure.
module frame_stream_scheduler #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [SEL_W-1:0]  filt_select_req,
    output logic [SEL_W-1:0]  filt_select_active,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic              frame_done,
    output logic [15:0]       frame_count
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned ENT_W = DATA_W + 2;

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [ADDR_W-1:0]  pix_addr_q;
    logic               rd_en_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               sop_fl_q, eop_fl_q;
    logic [ENT_W-1:0]   buf_q [2];
    logic [1:0]         count_q;
    logic [SEL_W-1:0]   filt_q;
    logic               frame_done_q;
    logic [15:0]        frame_count_q;

    logic       pop, eop_pop, issue, latch_sel, last_pix, wr_idx;
    logic [2:0] occ_next;

    assign pop      = (count_q != 2'd0) && src_ready;
    assign eop_pop  = pop && buf_q[0][DATA_W];
    assign occ_next = 3'(count_q) + 3'(rd_en_q) - 3'(pop);
    assign last_pix = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(HEIGHT - 1));
    assign wr_idx   = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        latch_sel = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StStream;
                    latch_sel = 1'b1;
                end
            end
            StStream: begin
                // After an early restart the old frame's EOP may still be leaving the buffer.
                latch_sel = eop_pop;
                if (occ_next < 3'd2) begin
                    issue = 1'b1;
                    if (last_pix) state_d = StDrain;
                end
            end
            StDrain: begin
                // Restart once only the EOP beat remains so the next SOP follows with no gap.
                if (enable && (occ_next <= 3'd1)) begin
                    state_d   = StStream;
                    issue     = 1'b1;
                    latch_sel = (occ_next == 3'd0);
                end else if (!enable && (occ_next == 3'd0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            pix_addr_q    <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            sop_fl_q      <= 1'b0;
            eop_fl_q      <= 1'b0;
            filt_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= issue;
            frame_done_q <= eop_pop;
            if (eop_pop) frame_count_q <= frame_count_q + 16'd1;
            if (latch_sel) filt_q <= filt_select_req;
            if (issue) begin
                rd_addr_q <= pix_addr_q;
                sop_fl_q  <= (col_q == '0) && (row_q == '0);
                eop_fl_q  <= last_pix;
                if (last_pix) begin
                    col_q      <= '0;
                    row_q      <= '0;
                    pix_addr_q <= '0;
                end else begin
                    pix_addr_q <= pix_addr_q + ADDR_W'(1);
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
            end
        end
    end

    // rd_data is captured at the edge that closes the rd_en cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            count_q <= occ_next[1:0];
            if (pop) buf_q[0] <= buf_q[1];
            if (rd_en_q) buf_q[wr_idx] <= {sop_fl_q, eop_fl_q, rd_data};
        end
    end

    assign rd_en              = rd_en_q;
    assign rd_addr            = rd_addr_q;
    assign src_valid          = (count_q != 2'd0);
    assign src_data           = buf_q[0][DATA_W-1:0];
    assign src_eop            = buf_q[0][DATA_W];
    assign src_sop            = buf_q[0][DATA_W+1];
    assign filt_select_active = filt_q;
    assign frame_done         = frame_done_q;
    assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// Bench for frame_stream_scheduler: a beat/read index model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_frame_stream_scheduler;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned AW   = 17;
    localparam int unsigned DW   = 12;
    localparam int unsigned SW   = 2;
    localparam int          NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset, enable, src_ready;
    logic [SW-1:0] filt_select_req, filt_select_active;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, src_data;
    logic          src_valid, src_sop, src_eop, frame_done;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    frame_stream_scheduler #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .filt_select_req    (filt_select_req),
        .filt_select_active (filt_select_active),
        .rd_en              (rd_en),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .src_sop            (src_sop),
        .src_eop            (src_eop),
        .frame_done         (frame_done),
        .frame_count        (frame_count)
    );

    always #5 clk = ~clk;

    // Frame buffer holds its own address as pixel data.
    assign rd_data = rd_addr[DW-1:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: beats and reads must walk pixel indices 0..NPIX-1 in order, frame after frame.
    int            exp_pix = 0;
    int            exp_rd = 0;
    int            issued = 0;
    int            accepted = 0;
    logic [15:0]   mdl_frames = 16'd0;
    bit            done_exp = 1'b0;
    bit            held = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic [SW-1:0] frame_filt = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pix = 0; exp_rd = 0; issued = 0; accepted = 0;
            mdl_frames = 16'd0; done_exp = 1'b0; held = 1'b0;
        end else begin
            chk("m_frame_done", frame_done, done_exp);
            chk("m_frame_count", frame_count, mdl_frames);
            if (rd_en) begin
                chk("m_rd_addr", rd_addr, exp_rd);
                exp_rd = (exp_rd + 1) % NPIX;
                issued++;
            end
            chk("m_outstanding_le_2", (issued - accepted) <= 2, 1);
            if (held) chk("m_stall_valid", src_valid, 1);
            if (src_valid) begin
                chk("m_src_data", src_data, exp_pix);
                chk("m_src_sop", src_sop, exp_pix == 0);
                chk("m_src_eop", src_eop, exp_pix == NPIX - 1);
                if (held) chk("m_stall_data", src_data, held_data);
                if (src_sop) frame_filt = filt_select_active;
                else chk("m_filt_in_frame", filt_select_active, frame_filt);
            end
            done_exp = src_valid && src_ready && (exp_pix == NPIX - 1);
            if (src_valid && src_ready) begin
                accepted++;
                if (exp_pix == NPIX - 1) mdl_frames = mdl_frames + 16'd1;
                exp_pix = (exp_pix + 1) % NPIX;
            end
            held      = src_valid && !src_ready;
            held_data = src_data;
        end
    end

    // Caller raised enable (or released reset) just after an edge; that next edge is N.
    task automatic latency_check(input string tag);
        @(negedge clk);
        chk({tag, "_pre_rd_en"}, rd_en, 0);
        @(negedge clk);
        chk({tag, "_n_rd_en"}, rd_en, 0);
        chk({tag, "_n_valid"}, src_valid, 0);
        @(negedge clk);
        chk({tag, "_n1_rd_en"}, rd_en, 1);
        chk({tag, "_n1_rd_addr"}, rd_addr, 0);
        chk({tag, "_n1_valid"}, src_valid, 0);
        @(negedge clk);
        chk({tag, "_n2_valid"}, src_valid, 1);
        chk({tag, "_n2_data"}, src_data, 0);
        chk({tag, "_n2_sop"}, src_sop, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rpat;
        int         cyc;
        int         pulses;
        int         bad;
        bit         seen;

        rpat = 4'b1001;
        reset = 1'b1; enable = 1'b0; src_ready = 1'b1; filt_select_req = 2'd1;
        repeat (2) @(negedge clk);
        chk("rst_src_valid", src_valid, 0);
        chk("rst_src_data", src_data, 0);
        chk("rst_src_sop", src_sop, 0);
        chk("rst_src_eop", src_eop, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_filt_active", filt_select_active, 0);
        tick();
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_valid", src_valid, 0);
        end

        // Sustained stream, filter request changes 1->3 at beat 5 of frame 0.
        tick();
        enable = 1'b1;
        latency_check("t1");
        chk("t1_filt_b0", filt_select_active, 1);
        pulses = 0;
        for (int k = 1; k < NPIX; k++) begin
            @(negedge clk);
            chk("t1_valid", src_valid, 1);
            chk("t1_data", src_data, k);
            chk("t1_sop", src_sop, 0);
            chk("t1_eop", src_eop, k == NPIX - 1);
            chk("t1_filt_f0", filt_select_active, 1);
            if (frame_done) pulses++;
            if (k == 5) begin
                tick();
                filt_select_req = 2'd3;
            end
        end
        @(negedge clk);
        if (frame_done) pulses++;
        chk("t1_next_valid_no_bubble", src_valid, 1);
        chk("t1_next_data", src_data, 0);
        chk("t1_next_sop", src_sop, 1);
        chk("t1_frame_done_pulses", pulses, 1);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_filt_f1", filt_select_active, 3);

        // Backpressure 1,0,0,1 across frame 1.
        cyc = 0;
        while (frame_count != 16'd2 && cyc < 200) begin
            tick();
            src_ready = rpat[cyc % 4];
            cyc++;
        end
        chk("t2_stall_frame_count", frame_count, 2);
        tick();
        src_ready = 1'b1;

        // Fresh start, enable dropped at beat 3: frame still completes, then idle.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        latency_check("t3");
        for (int k = 1; k <= 3; k++) @(negedge clk);
        chk("t3_beat3", src_data, 3);
        tick();
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("t3_frame_done_seen", seen, 1);
        chk("t3_frame_count", frame_count, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_en || src_valid) bad++;
        end
        chk("t3_idle_quiet", bad, 0);
        chk("t3_frame_count_after", frame_count, 1);

        // Reset at beat 7 while stalled.
        tick();
        enable = 1'b1;
        latency_check("t4");
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (src_valid && src_data == 6) seen = 1'b1;
        end
        chk("t4_reach_beat6", seen, 1);
        tick();
        src_ready = 1'b0;
        @(negedge clk);
        chk("t4_beat7_held", src_data, 7);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_valid", src_valid, 0);
        chk("t4_async_rd_en", rd_en, 0);
        chk("t4_async_sop", src_sop, 0);
        chk("t4_async_frame_count", frame_count, 0);
        tick();
        tick();
        src_ready = 1'b1;
        reset = 1'b0;
        latency_check("t4r");

        enable = 1'b0;
        cyc = 0;
        while (frame_count != 16'd1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t5_final_frame_count", frame_count, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
